// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file plus trap/mret sequencer beside the EX stage.
// Trap/mret: 1 stall cycle, then a 1-cycle redirect+flush; CSR reads are combinational.
module csr_trap_ctrl #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] HART_ID   = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        csr_en,
  input  logic [2:0]  csr_func3,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  csr_rs1_idx,
  input  logic [31:0] csr_rs1_data,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        irq_i,
  output logic [31:0] csr_rdata,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  typedef enum logic [1:0] {S_IDLE, S_TRAP, S_RET} state_t;

  state_t      state_q, state_d;
  logic        mstatus_mie_q, mstatus_mpie_q, mie_meie_q;
  logic [31:0] mtvec_q, mepc_q, mscratch_q, mcause_q;
  logic [63:0] mcycle_q;

  logic        idle, int_pend, trap_take, mret_take, csr_act, csr_wr;
  logic [31:0] old_val, operand, new_val;

  assign idle      = (state_q == S_IDLE);
  assign int_pend  = irq_i & mstatus_mie_q & mie_meie_q;
  assign trap_take = idle & ex_valid & (int_pend | ecall_i | ebreak_i);
  assign mret_take = idle & ex_valid & mret_i & ~int_pend & ~ecall_i & ~ebreak_i;
  assign csr_act   = idle & ex_valid & csr_en;

  // func3[1] marks set/clear forms, which must not write when the source is x0/zimm 0.
  assign csr_wr = csr_act & ~trap_take & ~mret_take & (csr_func3[1:0] != 2'b00)
                & ~(csr_func3[1] & (csr_rs1_idx == 5'd0));

  assign operand   = csr_func3[2] ? {27'd0, csr_rs1_idx} : csr_rs1_data;
  assign csr_rdata = csr_act ? old_val : 32'd0;

  always_comb begin
    old_val = 32'd0;
    case (csr_addr)
      A_MSTATUS:  old_val = {24'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
      A_MIE:      old_val = {20'd0, mie_meie_q, 11'd0};
      A_MTVEC:    old_val = mtvec_q;
      A_MSCRATCH: old_val = mscratch_q;
      A_MEPC:     old_val = mepc_q & 32'hFFFF_FFFC;
      A_MCAUSE:   old_val = mcause_q;
      A_MIP:      old_val = {20'd0, irq_i, 11'd0};
      A_MCYCLE:   old_val = mcycle_q[31:0];
      A_MCYCLEH:  old_val = mcycle_q[63:32];
      A_MHARTID:  old_val = HART_ID;
      default:    old_val = 32'd0;
    endcase
  end

  always_comb begin
    new_val = old_val;
    case (csr_func3[1:0])
      2'b01:   new_val = operand;
      2'b10:   new_val = old_val | operand;
      2'b11:   new_val = old_val & ~operand;
      default: new_val = old_val;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_meie_q     <= 1'b0;
      mtvec_q        <= MTVEC_RST & 32'hFFFF_FFFC;
      mepc_q         <= 32'd0;
      mscratch_q     <= 32'd0;
      mcause_q       <= 32'd0;
    end else if (trap_take) begin
      mepc_q         <= ex_pc;
      mcause_q       <= int_pend ? 32'h8000_000B : (ecall_i ? 32'd11 : 32'd3);
      mstatus_mpie_q <= mstatus_mie_q;
      mstatus_mie_q  <= 1'b0;
    end else if (mret_take) begin
      mstatus_mie_q  <= mstatus_mpie_q;
      mstatus_mpie_q <= 1'b1;
    end else if (csr_wr) begin
      case (csr_addr)
        A_MSTATUS: begin
          mstatus_mie_q  <= new_val[3];
          mstatus_mpie_q <= new_val[7];
        end
        A_MIE:      mie_meie_q <= new_val[11];
        A_MTVEC:    mtvec_q    <= new_val & 32'hFFFF_FFFC;
        A_MSCRATCH: mscratch_q <= new_val;
        A_MEPC:     mepc_q     <= new_val;
        A_MCAUSE:   mcause_q   <= new_val;
        default: ;
      endcase
    end
  end

  // A software write to either half replaces the increment for that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q <= 64'd0;
    end else if (csr_wr && csr_addr == A_MCYCLE) begin
      mcycle_q[31:0] <= new_val;
    end else if (csr_wr && csr_addr == A_MCYCLEH) begin
      mcycle_q[63:32] <= new_val;
    end else begin
      mcycle_q <= mcycle_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (trap_take)      state_d = S_TRAP;
        else if (mret_take) state_d = S_RET;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_o     = 1'b0;
    flush_o     = 1'b0;
    redirect_o  = 1'b0;
    redirect_pc = 32'd0;
    case (state_q)
      S_IDLE: stall_o = trap_take | mret_take;
      S_TRAP: begin
        flush_o     = 1'b1;
        redirect_o  = 1'b1;
        redirect_pc = {mtvec_q[31:2], 2'b00};
      end
      S_RET: begin
        flush_o     = 1'b1;
        redirect_o  = 1'b1;
        redirect_pc = {mepc_q[31:2], 2'b00};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed vector table plus randomized run against a behavioural CSR/trap model.
module tb_csr_trap_ctrl;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0400;
  localparam logic [31:0] HART_ID   = 32'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, csr_en, ecall_i, ebreak_i, mret_i, irq_i;
  logic [31:0] ex_pc, csr_rs1_data;
  logic [2:0]  csr_func3;
  logic [11:0] csr_addr;
  logic [4:0]  csr_rs1_idx;
  logic [31:0] csr_rdata, redirect_pc;
  logic        stall_o, flush_o, redirect_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_trap_ctrl #(.MTVEC_RST(MTVEC_RST), .HART_ID(HART_ID)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_pc(ex_pc), .csr_en(csr_en),
    .csr_func3(csr_func3), .csr_addr(csr_addr), .csr_rs1_idx(csr_rs1_idx),
    .csr_rs1_data(csr_rs1_data), .ecall_i(ecall_i), .ebreak_i(ebreak_i), .mret_i(mret_i),
    .irq_i(irq_i), .csr_rdata(csr_rdata), .stall_o(stall_o), .flush_o(flush_o),
    .redirect_o(redirect_o), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic        ev;
    logic [31:0] pc;
    logic        ce;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [4:0]  idx;
    logic [31:0] rs1;
    logic        ec, eb, mr, irq;
    logic        chk_rd;
    logic [31:0] e_rd;
    logic        e_st, e_fl, e_rdr;
    logic [31:0] e_pc;
  } vec_t;

  // Architectural state as the programmer sees it, plus the one pending redirect.
  logic        m_mie, m_mpie, m_meie;
  logic [31:0] m_mtvec, m_mepc, m_mscratch, m_mcause;
  logic [63:0] m_cyc;
  bit          m_pend;
  logic [31:0] m_pend_pc;

  function automatic void model_reset();
    m_mie = 0; m_mpie = 0; m_meie = 0;
    m_mtvec = MTVEC_RST & ~32'd3; m_mepc = 0; m_mscratch = 0; m_mcause = 0;
    m_cyc = 0; m_pend = 0; m_pend_pc = 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a, input logic irq);
    case (a)
      12'h300: return (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
      12'h304: return m_meie ? 32'h800 : 32'h0;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc & ~32'd3;
      12'h342: return m_mcause;
      12'h344: return irq ? 32'h800 : 32'h0;
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hF14: return HART_ID;
      default: return 32'h0;
    endcase
  endfunction

  function automatic vec_t model_expect(input vec_t v);
    vec_t e = v;
    e.chk_rd = 1; e.e_rd = 0; e.e_st = 0; e.e_fl = 0; e.e_rdr = 0; e.e_pc = 0;
    if (m_pend) begin
      e.e_fl = 1; e.e_rdr = 1; e.e_pc = m_pend_pc;
    end else if (v.ev) begin
      e.e_st = (v.irq && m_mie && m_meie) || v.ec || v.eb || v.mr;
      if (v.ce) e.e_rd = m_read(v.addr, v.irq);
    end
    return e;
  endfunction

  function automatic void model_step(input vec_t v);
    bit          cyc_written = 0;
    logic [31:0] old, opnd, nv;
    if (m_pend) begin
      m_pend = 0;
    end else if (v.ev) begin
      if ((v.irq && m_mie && m_meie) || v.ec || v.eb) begin
        m_mcause  = (v.irq && m_mie && m_meie) ? 32'h8000_000B : (v.ec ? 32'd11 : 32'd3);
        m_mepc    = v.pc;
        m_mpie    = m_mie;
        m_mie     = 0;
        m_pend    = 1;
        m_pend_pc = m_mtvec & ~32'd3;
      end else if (v.mr) begin
        m_mie     = m_mpie;
        m_mpie    = 1;
        m_pend    = 1;
        m_pend_pc = m_mepc & ~32'd3;
      end else if (v.ce && (v.f3 inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7})
                   && !((v.f3 inside {3'd2, 3'd3, 3'd6, 3'd7}) && v.idx == 0)) begin
        old  = m_read(v.addr, v.irq);
        opnd = (v.f3 >= 3'd5) ? 32'(v.idx) : v.rs1;
        if (v.f3 == 3'd1 || v.f3 == 3'd5)      nv = opnd;
        else if (v.f3 == 3'd2 || v.f3 == 3'd6) nv = old | opnd;
        else                                   nv = old & ~opnd;
        case (v.addr)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h304: m_meie = nv[11];
          12'h305: m_mtvec = nv & ~32'd3;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc = nv;
          12'h342: m_mcause = nv;
          12'hB00: begin m_cyc = {m_cyc[63:32], nv}; cyc_written = 1; end
          12'hB80: begin m_cyc = {nv, m_cyc[31:0]}; cyc_written = 1; end
          default: ;
        endcase
      end
    end
    if (!cyc_written) m_cyc = m_cyc + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    ex_valid = v.ev; ex_pc = v.pc; csr_en = v.ce; csr_func3 = v.f3; csr_addr = v.addr;
    csr_rs1_idx = v.idx; csr_rs1_data = v.rs1; ecall_i = v.ec; ebreak_i = v.eb;
    mret_i = v.mr; irq_i = v.irq;
  endtask

  // Called just after a negedge; returns just after the following negedge.
  task automatic run(input vec_t v, input bit use_model, input string tag);
    vec_t e;
    drive(v);
    #1;
    e = use_model ? model_expect(v) : v;
    check({tag, ".stall"}, 32'(stall_o), 32'(e.e_st));
    check({tag, ".flush"}, 32'(flush_o), 32'(e.e_fl));
    check({tag, ".redirect"}, 32'(redirect_o), 32'(e.e_rdr));
    check({tag, ".redirect_pc"}, redirect_pc, e.e_pc);
    if (e.chk_rd) check({tag, ".rdata"}, csr_rdata, e.e_rd);
    @(posedge clk);
    model_step(v);
    @(negedge clk);
  endtask

  function automatic vec_t base();
    vec_t v;
    v.ev = 0; v.pc = 0; v.ce = 0; v.f3 = 0; v.addr = 0; v.idx = 0; v.rs1 = 0;
    v.ec = 0; v.eb = 0; v.mr = 0; v.irq = 0;
    v.chk_rd = 1; v.e_rd = 0; v.e_st = 0; v.e_fl = 0; v.e_rdr = 0; v.e_pc = 0;
    return v;
  endfunction

  function automatic vec_t op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                              input logic [31:0] rs1, input logic [31:0] erd);
    vec_t v = base();
    v.ev = 1; v.ce = 1; v.f3 = f3; v.addr = a; v.idx = idx; v.rs1 = rs1; v.e_rd = erd;
    return v;
  endfunction

  function automatic vec_t rd(input logic [11:0] a, input logic [31:0] erd);
    return op(3'b010, a, 5'd0, 32'hFFFF_FFFF, erd);
  endfunction

  function automatic vec_t redir(input logic [31:0] pc);
    vec_t v = base();
    v.e_fl = 1; v.e_rdr = 1; v.e_pc = pc;
    return v;
  endfunction

  vec_t tbl[$];
  vec_t v;
  logic [11:0] addrs[12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                             12'h344, 12'hB00, 12'hB80, 12'hF14, 12'h7C0, 12'h001};

  initial begin
    rst_n = 0;
    drive(base());
    #1;
    check("reset.stall", 32'(stall_o), 0);
    check("reset.redirect", 32'(redirect_o), 0);
    check("reset.flush", 32'(flush_o), 0);
    check("reset.redirect_pc", redirect_pc, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    model_reset();

    tbl.push_back(op(3'b001, 12'h340, 5'd5, 32'hDEAD_BEEF, 32'h0));
    tbl.push_back(rd(12'h340, 32'hDEAD_BEEF));
    tbl.push_back(op(3'b001, 12'h300, 5'd1, 32'h8, 32'h0));
    tbl.push_back(op(3'b001, 12'h304, 5'd1, 32'h800, 32'h0));
    v = base(); v.ev = 1; v.pc = 32'h100; v.irq = 1; v.e_st = 1; tbl.push_back(v);
    v = redir(32'h400); v.irq = 1; v.ev = 1; v.ec = 1; tbl.push_back(v);
    tbl.push_back(rd(12'h341, 32'h100));
    tbl.push_back(rd(12'h342, 32'h8000_000B));
    tbl.push_back(rd(12'h300, 32'h80));
    v = op(3'b001, 12'h340, 5'd3, 32'h1234, 32'hDEAD_BEEF); v.pc = 32'h200; v.ec = 1; v.e_st = 1;
    tbl.push_back(v);
    tbl.push_back(redir(32'h400));
    tbl.push_back(rd(12'h340, 32'hDEAD_BEEF));
    tbl.push_back(rd(12'h342, 32'd11));
    v = base(); v.ev = 1; v.pc = 32'h444; v.mr = 1; v.e_st = 1; tbl.push_back(v);
    tbl.push_back(redir(32'h200));
    tbl.push_back(rd(12'h300, 32'h80));
    tbl.push_back(op(3'b010, 12'h305, 5'd0, 32'h0000_FFFF, 32'h400));
    tbl.push_back(rd(12'h305, 32'h400));
    tbl.push_back(op(3'b001, 12'h300, 5'd1, 32'hFFFF_FFFF, 32'h80));
    tbl.push_back(rd(12'h300, 32'h88));
    tbl.push_back(op(3'b111, 12'h300, 5'd8, 32'h0, 32'h88));
    tbl.push_back(rd(12'h300, 32'h80));
    tbl.push_back(op(3'b001, 12'hF14, 5'd1, 32'h55, HART_ID));
    tbl.push_back(rd(12'hF14, HART_ID));
    tbl.push_back(op(3'b001, 12'h7C0, 5'd1, 32'h55, 32'h0));
    tbl.push_back(rd(12'h7C0, 32'h0));
    tbl.push_back(op(3'b101, 12'h305, 5'h13, 32'h0, 32'h400));
    tbl.push_back(rd(12'h305, 32'h10));
    v = rd(12'h344, 32'h800); v.irq = 1; tbl.push_back(v);
    tbl.push_back(rd(12'h304, 32'h800));
    v = base(); v.ec = 1; v.irq = 1; v.ce = 1; v.addr = 12'h340; tbl.push_back(v);
    tbl.push_back(op(3'b001, 12'h341, 5'd1, 32'h203, 32'h200));
    tbl.push_back(rd(12'h341, 32'h200));
    tbl.push_back(op(3'b001, 12'hB80, 5'd1, 32'd5, 32'h0));
    v = op(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF, 32'h0); v.chk_rd = 0; tbl.push_back(v);
    tbl.push_back(rd(12'hB00, 32'hFFFF_FFFF));
    tbl.push_back(rd(12'hB80, 32'd6));
    tbl.push_back(rd(12'hB00, 32'd1));

    foreach (tbl[i]) run(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Reset while the redirect is due: the pulse must never appear.
    v = base(); v.ev = 1; v.pc = 32'h300; v.ec = 1; v.e_st = 1;
    run(v, 1'b0, "pre_rst_ecall");
    rst_n = 0;
    drive(base());
    #1;
    check("rst_in_trap.redirect", 32'(redirect_o), 0);
    check("rst_in_trap.flush", 32'(flush_o), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    model_reset();
    run(rd(12'h340, 32'h0), 1'b0, "post_rst.mscratch");
    run(rd(12'h305, MTVEC_RST), 1'b0, "post_rst.mtvec");
    run(rd(12'h300, 32'h0), 1'b0, "post_rst.mstatus");
    run(rd(12'h341, 32'h0), 1'b0, "post_rst.mepc");
    run(rd(12'h342, 32'h0), 1'b0, "post_rst.mcause");
    run(rd(12'h304, 32'h0), 1'b0, "post_rst.mie");

    for (int n = 0; n < 600; n++) begin
      v = base();
      v.ev   = ($urandom_range(0, 9) < 8);
      v.pc   = $urandom;
      v.ce   = $urandom_range(0, 1);
      v.f3   = 3'($urandom_range(0, 7));
      v.addr = addrs[$urandom_range(0, 11)];
      v.idx  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      v.rs1  = ($urandom_range(0, 3) == 0) ? 32'h0000_0888 : $urandom;
      v.ec   = ($urandom_range(0, 15) == 0);
      v.eb   = ($urandom_range(0, 15) == 0);
      v.mr   = ($urandom_range(0, 7) == 0);
      v.irq  = $urandom_range(0, 1);
      run(v, 1'b1, $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
